// File: rtl/uart_vga_pkg.sv
// uart_vga_pkg: geometry constants shared by the bit RAM, the renderer and the UART writer.
package uart_vga_pkg;
    localparam int ROWS          = 64;
    localparam int ROW_BITS      = 160;
    localparam int BYTES_PER_ROW = ROW_BITS / 8;
    localparam int ROW_LSB       = 5;
    localparam int ROW_MSB       = 10;
endpackage

// File: rtl/uart_vga_bit_ram.sv
// uart_vga_bit_ram: byte-writable, row-readable bit map for the UART debug display.
module uart_vga_bit_ram #(
    parameter int ROWS     = uart_vga_pkg::ROWS,
    parameter int ROW_BITS = uart_vga_pkg::ROW_BITS,
    parameter int ADDR_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   read_address,
    input  logic [ADDR_W-1:0]   write_address,
    input  logic [7:0]          ram_in,
    input  logic                we,
    output logic [ROW_BITS-1:0] ram_out
);
    localparam int RW    = $clog2(ROWS);
    localparam int LANES = ROW_BITS / 8;
    localparam int LSB   = uart_vga_pkg::ROW_LSB;

    logic [ROW_BITS-1:0] r_mem [ROWS] = '{default: '0};
    logic [ROW_BITS-1:0] r_out;
    logic [RW-1:0]       w_rd_row;
    logic [RW-1:0]       w_wr_row;
    logic [LSB-1:0]      w_lane;
    logic                w_rd_ok;
    logic [LANES-1:0]    w_mask;

    assign w_rd_row = read_address[RW-1:0];
    assign w_rd_ok  = read_address < ADDR_W'(ROWS);
    assign w_wr_row = write_address[LSB+RW-1:LSB];
    assign w_lane   = write_address[LSB-1:0];

    // lanes beyond the row width match no mask bit, so those writes vanish
    for (genvar g = 0; g < LANES; g++) begin : g_mask
        assign w_mask[g] = we && (w_lane == LSB'(g));
    end

    always_ff @(posedge clk) begin
        if (!rst)
            for (int l = 0; l < LANES; l++)
                if (w_mask[l]) r_mem[w_wr_row][l*8 +: 8] <= ram_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_out <= '0;
        else     r_out <= w_rd_ok ? r_mem[w_rd_row] : '0;
    end

    assign ram_out = r_out;
endmodule

// File: tb/tb_uart_vga_bit_ram.sv
// tb_uart_vga_bit_ram: directed and random checks of the bit RAM against an array model.
module tb_uart_vga_bit_ram;
    logic         clk = 0;
    logic         rst = 1;
    logic [31:0]  read_address = 0;
    logic [31:0]  write_address = 0;
    logic [7:0]   ram_in = 0;
    logic         we = 0;
    logic [159:0] ram_out;

    logic [159:0] model [64];
    int compared = 0;
    int mismatched = 0;

    uart_vga_bit_ram dut (
        .clk(clk), .rst(rst), .read_address(read_address), .write_address(write_address),
        .ram_in(ram_in), .we(we), .ram_out(ram_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] exp);
        compared++;
        assert (ram_out === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, ram_out, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [31:0] ra, input logic [31:0] wa,
                       input logic [7:0] d, input logic w);
        logic [159:0] exp;
        int row, lane;
        read_address = ra; write_address = wa; ram_in = d; we = w;
        exp = (ra < 64) ? model[ra] : '0;
        row = int'(wa[10:5]);
        lane = int'(wa[4:0]);
        if (w && lane < 20) model[row][lane*8 +: 8] = d;
        @(posedge clk); #1;
        chk(tag, exp);
    endtask

    function automatic logic [31:0] wad(input int row, input int lane);
        return 32'((row << 5) | lane);
    endfunction

    initial begin
        logic [159:0] exp;
        foreach (model[i]) model[i] = '0;
        #2 chk("reset_out", '0);
        @(posedge clk); #1 chk("reset_hold", '0);
        rst = 0;
        for (int r = 0; r < 64; r++) cyc("init_read", r, 0, 0, 0);

        cyc("byte_wr", 0, wad(3, 2), 8'hA5, 1);
        cyc("byte_rd", 3, 0, 0, 0);
        exp = '0; exp[23:16] = 8'hA5;
        chk("byte_rd_const", exp);

        for (int l = 0; l < 20; l++) cyc("row63_wr", 70, wad(63, l), 8'(l), 1);
        cyc("row63_rd", 63, 0, 0, 0);
        exp = '0;
        for (int l = 0; l < 20; l++) exp[l*8 +: 8] = 8'(l);
        chk("row63_const", exp);

        cyc("lane1_wr", 0, wad(1, 3), 8'h5A, 1);
        cyc("ign_lane", 0, wad(1, 25), 8'hFF, 1);
        cyc("ign_lane_rd", 1, 0, 0, 0);
        exp = '0; exp[31:24] = 8'h5A;
        chk("ign_lane_const", exp);
        cyc("oor_66", 66, 0, 0, 0);
        chk("oor_66_zero", '0);
        cyc("hi_bits_wr", 0, 32'hFFFF_F800 | wad(7, 4), 8'hC3, 1);
        cyc("hi_bits_rd", 7, 0, 0, 0);

        cyc("coll_pre", 0, wad(5, 0), 8'h81, 1);
        cyc("coll_same", 5, wad(5, 0), 8'h3C, 1);
        exp = '0; exp[7:0] = 8'h81;
        chk("coll_old", exp);
        cyc("coll_next", 5, 0, 0, 0);
        exp[7:0] = 8'h3C;
        chk("coll_new", exp);

        read_address = 3; write_address = wad(3, 2); ram_in = 8'h11; we = 1;
        #2 rst = 1;
        #1 chk("rst_async", '0);
        @(posedge clk); #1 chk("rst_edge", '0);
        we = 0; rst = 0;
        cyc("rst_keep3", 3, 0, 0, 0);
        cyc("rst_keep63", 63, 0, 0, 0);
        cyc("rst_keep5", 5, 0, 0, 0);

        for (int i = 0; i < 400; i++)
            cyc("random", $urandom_range(70), {$urandom_range(7), 21'd0} | wad($urandom_range(63), $urandom_range(31)),
                8'($urandom), 1'($urandom));
        for (int r = 0; r < 64; r++) cyc("final_read", r, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
